// File: rtl/mem_responder.sv
// Word-addressed memory target with programmable wait states.
// One request at a time: capture, wait, access, single-cycle acknowledge.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_l,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [32:0] BYTE_SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    wr_q;
  logic [31:0]             addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             mem [DEPTH];
  logic [31:0]             offset;
  logic                    acc_err;
  logic [DEPTH_LOG2-1:0]   word_idx;

  // Offset wraps for addresses below BASE_ADDR, so they fail the range test.
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    acc_err  = (addr_q[1:0] != 2'b00) || ({1'b0, offset} >= BYTE_SPAN);
    word_idx = offset[DEPTH_LOG2+1:2];
  end

  // Storage is never cleared; reset only suppresses a pending commit.
  always_ff @(posedge clock) begin
    if (reset_l && state == S_ACCESS && !acc_err && wr_q)
      mem[word_idx] <= wdata_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_l) begin
      state <= S_IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wr_q    <= wr;
            wdata_q <= wdata;
            cnt     <= 4'(WAIT_CYCLES);
            busy    <= 1'b1;
            state   <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!wr_q)
            rdata <= acc_err ? '0 : mem[word_idx];
          err   <= acc_err;
          ack   <= 1'b1;
          state <= S_RESP;
        end
        S_RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, protocol/reset
// sequences and randomized traffic against a word-array reference model.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset_l = 1'b0;

  logic        req, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ack, busy, err;

  logic        req0, wr0;
  logic [31:0] addr0, wdata0;
  logic [31:0] rdata0;
  logic        ack0, busy0, err0;

  int          sel = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] c_rdata;
  logic        c_ack, c_busy, c_err;

  logic [31:0] mdl [256];
  logic [31:0] exp_rd;

  typedef struct {
    int          sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  mem_responder dut (
    .clock  (clock),
    .reset_l(reset_l),
    .req    (req),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ack    (ack),
    .busy   (busy),
    .err    (err)
  );

  mem_responder #(
    .DEPTH_LOG2 (4),
    .WAIT_CYCLES(0),
    .BASE_ADDR  (32'h0000_0100)
  ) dut_w0 (
    .clock  (clock),
    .reset_l(reset_l),
    .req    (req0),
    .wr     (wr0),
    .addr   (addr0),
    .wdata  (wdata0),
    .rdata  (rdata0),
    .ack    (ack0),
    .busy   (busy0),
    .err    (err0)
  );

  always #5 clock = ~clock;

  always_comb begin
    c_rdata = (sel != 0) ? rdata0 : rdata;
    c_ack   = (sel != 0) ? ack0   : ack;
    c_busy  = (sel != 0) ? busy0  : busy;
    c_err   = (sel != 0) ? err0   : err;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, expv);
    end
  endtask

  // An acknowledge must never last two consecutive cycles.
  logic ack_prev = 1'b0, ack0_prev = 1'b0;
  always @(negedge clock) begin
    if (ack) begin
      n_checks++;
      if (ack_prev) begin
        n_fail++;
        $display("FAIL ack_width: ack high 2 cycles, expected 1");
      end
    end
    if (ack0) begin
      n_checks++;
      if (ack0_prev) begin
        n_fail++;
        $display("FAIL ack0_width: ack high 2 cycles, expected 1");
      end
    end
    ack_prev  <= ack;
    ack0_prev <= ack0;
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (sel != 0) begin
      req0 = r; wr0 = w; addr0 = a; wdata0 = d;
    end else begin
      req = r; wr = w; addr = a; wdata = d;
    end
  endtask

  // Starts and ends on a falling edge; scrambles inputs right after capture.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input int wc, output logic [31:0] rd, output logic e);
    int lat;
    drive(1'b1, w, a, d);
    @(posedge clock);
    @(negedge clock);
    drive(1'b0, ~w, ~a, ~d);
    lat = 1;
    while (1) begin
      check("busy_during", {31'b0, c_busy}, 32'd1);
      if (c_ack || lat >= 40) break;
      @(negedge clock);
      lat++;
    end
    check("latency", 32'(lat), 32'(wc + 2));
    rd = c_rdata;
    e  = c_err;
    @(negedge clock);
    check("ack_end",  {31'b0, c_ack},  32'd0);
    check("busy_end", {31'b0, c_busy}, 32'd0);
    check("err_end",  {31'b0, c_err},  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, d;
    logic        e, w, e_exp;
    int          n, k;

    req = 0; wr = 0; addr = '0; wdata = '0;
    req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;

    tbl.push_back('{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000});
    tbl.push_back('{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF});
    tbl.push_back('{0, 1'b1, 32'h0000_0012, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF});
    tbl.push_back('{0, 1'b1, 32'h0000_0400, 32'h2222_2222, 1'b1, 32'hDEAD_BEEF});
    tbl.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hC0DE_0000});
    tbl.push_back('{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF});
    tbl.push_back('{0, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hC0DE_00FF});
    tbl.push_back('{0, 1'b0, 32'h0000_03FD, 32'h0,         1'b1, 32'h0000_0000});
    tbl.push_back('{0, 1'b1, 32'h0000_0008, 32'h0000_0001, 1'b0, 32'h0000_0000});
    tbl.push_back('{0, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0000_0001});
    tbl.push_back('{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000});
    tbl.push_back('{0, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0000_0000});
    tbl.push_back('{0, 1'b0, 32'h0000_0014, 32'h0,         1'b0, 32'hC0DE_0005});
    tbl.push_back('{1, 1'b1, 32'h0000_0100, 32'h1234_5678, 1'b0, 32'h0000_0000});
    tbl.push_back('{1, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'h1234_5678});
    tbl.push_back('{1, 1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'h0000_0000});
    tbl.push_back('{1, 1'b1, 32'h0000_013C, 32'hAABB_CCDD, 1'b0, 32'h0000_0000});
    tbl.push_back('{1, 1'b0, 32'h0000_013C, 32'h0,         1'b0, 32'hAABB_CCDD});
    tbl.push_back('{1, 1'b0, 32'h0000_0140, 32'h0,         1'b1, 32'h0000_0000});
    tbl.push_back('{1, 1'b0, 32'h0000_0102, 32'h0,         1'b1, 32'h0000_0000});

    // Reset, then quiet idle.
    reset_l = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_l = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_ack",   {31'b0, ack},  32'd0);
      check("idle_busy",  {31'b0, busy}, 32'd0);
      check("idle_err",   {31'b0, err},  32'd0);
      check("idle_rdata", rdata,         32'd0);
      check("idle_busy0", {31'b0, busy0}, 32'd0);
    end

    // Fill every word so later reads have defined contents.
    sel = 0;
    for (int i = 0; i < 256; i++) begin
      d = 32'hC0DE_0000 | 32'(i);
      txn(1'b1, 32'(i * 4), d, 2, rd, e);
      check("init_err", {31'b0, e}, 32'd0);
      mdl[i] = d;
    end

    foreach (tbl[i]) begin
      sel = tbl[i].sel;
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, (sel != 0) ? 0 : 2, rd, e);
      check($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      if (sel == 0 && tbl[i].wr && !tbl[i].exp_err)
        mdl[tbl[i].addr[9:2]] = tbl[i].wdata;
    end
    sel = 0;

    // Held request with the address changed after capture.
    req = 1; wr = 0; addr = 32'h10; wdata = '0;
    @(posedge clock);
    @(negedge clock);
    addr = 32'h20;
    n = 1;
    while (!ack && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("proto_lat1", 32'(n), 32'd4);
    check("proto_rd1", rdata, mdl[4]);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ack && n < 40);
    check("proto_period", 32'(n), 32'd5);
    check("proto_rd2", rdata, mdl[8]);
    req = 0;
    @(negedge clock);
    check("proto_ack_end",  {31'b0, ack},  32'd0);
    check("proto_busy_end", {31'b0, busy}, 32'd0);

    // Reset during the wait phase of a write aborts it.
    req = 1; wr = 1; addr = 32'h8; wdata = 32'h55AA_55AA;
    @(posedge clock);
    @(negedge clock);
    req = 0;
    reset_l = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rst_ack",   {31'b0, ack},  32'd0);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_err",   {31'b0, err},  32'd0);
    check("rst_rdata", rdata,         32'd0);
    reset_l = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("rst_no_ack", {31'b0, ack}, 32'd0);
    end
    txn(1'b0, 32'h8, 32'h0, 2, rd, e);
    check("rst_read_err", {31'b0, e}, 32'd0);
    check("rst_read_rd", rd, mdl[2]);
    exp_rd = mdl[2];

    // Random traffic against the word-array model (BASE_ADDR 0, 1 KiB span).
    for (int t = 0; t < 200; t++) begin
      k = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      case (k)
        7:       a = (32'($urandom_range(0, 255)) * 4) + 32'($urandom_range(1, 3));
        8:       a = 32'h400 + 32'($urandom_range(0, 1023)) * 4;
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, 255)) * 4;
      endcase
      e_exp = (a % 4 != 0) || (a >= 32'd1024);
      if (!w)
        exp_rd = e_exp ? 32'd0 : mdl[a / 4];
      else if (!e_exp)
        mdl[a / 4] = d;
      txn(w, a, d, 2, rd, e);
      check("rand_err", {31'b0, e}, {31'b0, e_exp});
      check("rand_rdata", rd, exp_rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
